// File: rtl/pcq_clks_seq.sv
// pcq_clks_seq: NUM_DOM-domain thold sequencer with GAP-spaced PM raise/lower, sticky fast-xstop hold
// and an STG-deep staging pipeline that goes transparent under ccflush_dc. PCQ_CLKS_SEQ_CNT_EN adds seq_cnt.
//
// state | meaning
// IDLE  | no PM hold, waiting for pm_raise_req
// RAISE | setting PM holds, one domain slot every GAP cycles, lowest domain first
// HELD  | all slots raised, pm_ack asserted
// LOWER | clearing PM holds, one slot every GAP cycles, highest domain first
module pcq_clks_seq #(
    parameter int NUM_DOM = 4,
    parameter int GAP     = 3,
    parameter int STG     = 2
) (
    input  logic               nclk,
    input  logic               rst_n,
    input  logic               thold_in,
    input  logic               sg_in,
    input  logic               fce_in,
    input  logic               ccflush_dc,
    input  logic               pm_raise_req,
    input  logic [NUM_DOM-1:0] dom_mask,
    input  logic               fast_xstop,
    output logic [NUM_DOM-1:0] thold_out,
    output logic               sg_out,
    output logic               fce_out,
    output logic               pm_ack,
    output logic               seq_busy
`ifdef PCQ_CLKS_SEQ_CNT_EN
   ,output logic [15:0]        seq_cnt
`endif
);

    localparam int IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
    localparam int GAP_W = $clog2(GAP + 1);

    typedef enum logic [1:0] {S_IDLE, S_RAISE, S_HELD, S_LOWER} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [NUM_DOM-1:0] pm_hold_q, pm_hold_d;
    logic               xstop_hold_q, xstop_hold_d;
    logic               pm_ack_q, pm_ack_d;
    logic               slot_end;
    logic               last_slot;
    logic [NUM_DOM-1:0] raw;

    assign slot_end  = (gap_cnt_q == GAP_W'(GAP - 1));
    assign last_slot = (idx_q == IDX_W'(NUM_DOM - 1));

    always_ff @(posedge nclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            gap_cnt_q    <= '0;
            pm_hold_q    <= '0;
            xstop_hold_q <= 1'b0;
            pm_ack_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            gap_cnt_q    <= gap_cnt_d;
            pm_hold_q    <= pm_hold_d;
            xstop_hold_q <= xstop_hold_d;
            pm_ack_q     <= pm_ack_d;
        end
    end

    // idx counts slots in both directions; LOWER maps slot k onto domain NUM_DOM-1-k.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        gap_cnt_d = gap_cnt_q;
        pm_hold_d = pm_hold_q;
        unique case (state_q)
            S_IDLE: begin
                pm_hold_d = '0;
                idx_d     = '0;
                gap_cnt_d = '0;
                if (pm_raise_req) begin
                    state_d      = S_RAISE;
                    pm_hold_d[0] = dom_mask[0];
                end
            end
            S_RAISE: begin
                if (slot_end) begin
                    gap_cnt_d = '0;
                    if (last_slot) begin
                        state_d = S_HELD;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        for (int i = 0; i < NUM_DOM; i++) begin
                            if (i == int'(idx_q) + 1 && dom_mask[i]) pm_hold_d[i] = 1'b1;
                        end
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            S_HELD: begin
                if (!pm_raise_req) begin
                    state_d              = S_LOWER;
                    idx_d                = '0;
                    gap_cnt_d            = '0;
                    pm_hold_d[NUM_DOM-1] = 1'b0;
                end
            end
            S_LOWER: begin
                if (slot_end) begin
                    gap_cnt_d = '0;
                    if (last_slot) begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        for (int i = 0; i < NUM_DOM; i++) begin
                            if (i == NUM_DOM - 2 - int'(idx_q)) pm_hold_d[i] = 1'b0;
                        end
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign xstop_hold_d = xstop_hold_q | fast_xstop;
    assign pm_ack_d     = (state_d == S_HELD);

    always_comb begin
        seq_busy = (state_q == S_RAISE) || (state_q == S_LOWER);
        pm_ack   = pm_ack_q;
    end

    assign raw = pm_hold_q | {NUM_DOM{thold_in | xstop_hold_q}};

    generate
        if (STG == 0) begin : g_no_stg
            assign thold_out = raw;
            assign sg_out    = sg_in;
            assign fce_out   = fce_in;
        end else begin : g_stg
            logic [NUM_DOM-1:0] thold_stg_q [STG];
            logic [NUM_DOM-1:0] thold_stg_d [STG];
            logic [STG-1:0]     sg_stg_q, sg_stg_d;
            logic [STG-1:0]     fce_stg_q, fce_stg_d;

            always_comb begin
                thold_stg_d[0] = raw;
                sg_stg_d       = '0;
                fce_stg_d      = '0;
                sg_stg_d[0]    = sg_in;
                fce_stg_d[0]   = fce_in;
                for (int s = 1; s < STG; s++) begin
                    thold_stg_d[s] = thold_stg_q[s-1];
                    sg_stg_d[s]    = sg_stg_q[s-1];
                    fce_stg_d[s]   = fce_stg_q[s-1];
                end
            end

            always_ff @(posedge nclk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int s = 0; s < STG; s++) thold_stg_q[s] <= '1;
                    sg_stg_q  <= '0;
                    fce_stg_q <= '0;
                end else begin
                    for (int s = 0; s < STG; s++) thold_stg_q[s] <= thold_stg_d[s];
                    sg_stg_q  <= sg_stg_d;
                    fce_stg_q <= fce_stg_d;
                end
            end

            // Flush bypasses the pipeline at the output only; the stages keep shifting underneath.
            assign thold_out = ccflush_dc ? raw    : thold_stg_q[STG-1];
            assign sg_out    = ccflush_dc ? sg_in  : sg_stg_q[STG-1];
            assign fce_out   = ccflush_dc ? fce_in : fce_stg_q[STG-1];
        end
    endgenerate

`ifdef PCQ_CLKS_SEQ_CNT_EN
    logic [15:0] seq_cnt_q, seq_cnt_d;

    always_comb begin
        seq_cnt_d = seq_cnt_q;
        if (state_q == S_RAISE && state_d == S_HELD && seq_cnt_q != 16'hFFFF) begin
            seq_cnt_d = seq_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge nclk or negedge rst_n) begin
        if (!rst_n) seq_cnt_q <= '0;
        else        seq_cnt_q <= seq_cnt_d;
    end

    assign seq_cnt = seq_cnt_q;
`endif

endmodule

// File: tb/tb_pcq_clks_seq.sv
// Scoreboard bench for pcq_clks_seq: an elapsed-time model of the PM sequence plus a delay-line view
// of staging predicts each cycle's outputs; a negedge monitor pops and compares them.
module tb_pcq_clks_seq;
    localparam int N   = 4;
    localparam int GAP = 3;
    localparam int STG = 2;

    logic         nclk = 1'b0;
    logic         rst_n = 1'b0;
    logic         thold_in = 1'b0, sg_in = 1'b0, fce_in = 1'b0, ccflush_dc = 1'b0;
    logic         pm_raise_req = 1'b0, fast_xstop = 1'b0;
    logic [N-1:0] dom_mask = '1;
    logic [N-1:0] thold_out;
    logic         sg_out, fce_out, pm_ack, seq_busy;
`ifdef PCQ_CLKS_SEQ_CNT_EN
    logic [15:0]  seq_cnt;
`endif

    pcq_clks_seq #(.NUM_DOM(N), .GAP(GAP), .STG(STG)) dut (
        .nclk         (nclk),
        .rst_n        (rst_n),
        .thold_in     (thold_in),
        .sg_in        (sg_in),
        .fce_in       (fce_in),
        .ccflush_dc   (ccflush_dc),
        .pm_raise_req (pm_raise_req),
        .dom_mask     (dom_mask),
        .fast_xstop   (fast_xstop),
        .thold_out    (thold_out),
        .sg_out       (sg_out),
        .fce_out      (fce_out),
        .pm_ack       (pm_ack),
        .seq_busy     (seq_busy)
`ifdef PCQ_CLKS_SEQ_CNT_EN
       ,.seq_cnt      (seq_cnt)
`endif
    );

    always #5 nclk = ~nclk;

    typedef struct {
        logic [N-1:0] th;
        logic         sg;
        logic         fce;
        logic         ack;
        logic         busy;
        logic [15:0]  cnt;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: phase plus elapsed edges since the sequence started.
    typedef enum {P_IDLE, P_UP, P_ON, P_DOWN} phase_t;
    phase_t       m_phase;
    int           m_t;
    logic [N-1:0] m_hold;
    logic         m_xstop;
    logic [15:0]  m_cnt;
    logic [N-1:0] tq[$];
    logic         sq[$], fq[$];

    task automatic model_reset();
        m_phase = P_IDLE;
        m_t     = 0;
        m_hold  = '0;
        m_xstop = 1'b0;
        m_cnt   = '0;
        tq.delete(); sq.delete(); fq.delete();
        for (int s = 0; s < STG; s++) begin
            tq.push_back('1);
            sq.push_back(1'b0);
            fq.push_back(1'b0);
        end
    endtask

    // Applies one clock edge using the inputs the DUT sampled at it.
    task automatic model_edge();
        case (m_phase)
            P_IDLE: if (pm_raise_req) begin
                m_phase   = P_UP;
                m_t       = 0;
                m_hold[0] = dom_mask[0];
            end
            P_UP: begin
                m_t++;
                if (m_t == N * GAP) begin
                    m_phase = P_ON;
                    if (m_cnt != 16'hFFFF) m_cnt++;
                end else if (m_t % GAP == 0) begin
                    m_hold[m_t / GAP] = dom_mask[m_t / GAP];
                end
            end
            P_ON: if (!pm_raise_req) begin
                m_phase     = P_DOWN;
                m_t         = 0;
                m_hold[N-1] = 1'b0;
            end
            P_DOWN: begin
                m_t++;
                if (m_t == N * GAP) m_phase = P_IDLE;
                else if (m_t % GAP == 0) m_hold[N-1-(m_t / GAP)] = 1'b0;
            end
            default: m_phase = P_IDLE;
        endcase
        if (fast_xstop) m_xstop = 1'b1;
    endtask

    task automatic cycle(input logic r, input logic req, input logic [N-1:0] msk,
                         input logic xs, input logic th, input logic fl);
        logic [N-1:0] raw_prev, raw_now;
        exp_t e;
        @(posedge nclk);
        #1;
        raw_prev = m_hold | {N{thold_in | m_xstop}};
        if (rst_n) begin
            if (STG > 0) begin
                tq.push_back(raw_prev); void'(tq.pop_front());
                sq.push_back(sg_in);    void'(sq.pop_front());
                fq.push_back(fce_in);   void'(fq.pop_front());
            end
            model_edge();
        end
        rst_n        = r;
        pm_raise_req = req;
        dom_mask     = msk;
        fast_xstop   = xs;
        thold_in     = th;
        ccflush_dc   = fl;
        sg_in        = 1'($urandom_range(0, 1));
        fce_in       = 1'($urandom_range(0, 1));
        if (!r) model_reset();
        raw_now = m_hold | {N{thold_in | m_xstop}};
        if (STG == 0 || fl) begin
            e.th = raw_now; e.sg = sg_in; e.fce = fce_in;
        end else begin
            e.th = tq[0]; e.sg = sq[0]; e.fce = fq[0];
        end
        e.ack  = (m_phase == P_ON);
        e.busy = (m_phase == P_UP) || (m_phase == P_DOWN);
        e.cnt  = m_cnt;
        sb.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge nclk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("thold_out", 32'(thold_out), 32'(e.th));
                chk("sg_out",    32'(sg_out),    32'(e.sg));
                chk("fce_out",   32'(fce_out),   32'(e.fce));
                chk("pm_ack",    32'(pm_ack),    32'(e.ack));
                chk("seq_busy",  32'(seq_busy),  32'(e.busy));
`ifdef PCQ_CLKS_SEQ_CNT_EN
                chk("seq_cnt",   32'(seq_cnt),   32'(e.cnt));
`endif
            end
        end
    end

    initial begin : stim
        model_reset();
        // Reset and release.
        repeat (3) cycle(1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0);
        repeat (4) cycle(1'b1, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0);
        // Full raise then full lower, all domains.
        repeat (16) cycle(1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
        repeat (16) cycle(1'b1, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0);
        // Masked raise and lower.
        repeat (16) cycle(1'b1, 1'b1, 4'b1010, 1'b0, 1'b0, 1'b0);
        repeat (16) cycle(1'b1, 1'b0, 4'b1010, 1'b0, 1'b0, 1'b0);
        // Flush with thold_in toggling.
        for (int k = 0; k < 8; k++) cycle(1'b1, 1'b0, 4'b1111, 1'b0, 1'(k % 2), 1'b1);
        // Xstop pulse mid-raise; must persist through lower and idle.
        repeat (5) cycle(1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0);
        repeat (12) cycle(1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
        repeat (20) cycle(1'b1, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0);
        repeat (2) cycle(1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0);
        // Randomised segments with occasional async resets, flushes and xstops.
        for (int seg = 0; seg < 70; seg++) begin
            logic         req, fl;
            logic [N-1:0] msk;
            int           len;
            len = $urandom_range(3, 30);
            req = 1'($urandom_range(0, 1));
            fl  = ($urandom_range(0, 5) == 0);
            msk = ($urandom_range(0, 2) == 0) ? 4'b1111 : 4'($urandom);
            for (int c = 0; c < len; c++) begin
                cycle(($urandom_range(0, 199) != 0), req, msk,
                      ($urandom_range(0, 249) == 0), ($urandom_range(0, 9) == 0), fl);
            end
        end
        repeat (2) cycle(1'b1, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0);
        @(negedge nclk);
        #1;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
